reg_file_port_arbiter: RTL and testbench
========================================

# reg_file_port_arbiter

- Shares the single write port and single read port of a 1-write/1-read register file among `NumReq` requesters.
- Each port has its own independent round-robin arbiter. Requesters use valid/ready handshakes.
- Read responses are registered and returned one cycle after the grant, tagged with the requester ID.
- Sits between encoder/controller front-ends and a shared register file set. Also forwards a clear command that takes priority over writes.

## Interface
Parameters:
- `NumReq`, 4, number of requesters (≥2).
- `DataWidth`, 32, register data width.
- `NumRegs`, 32, number of registers.
- `NumRegsWidth`, `$clog2(NumRegs)`, derived; do not override.
- `NumReqWidth`, `$clog2(NumReq)`, derived; do not override.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `clr_i`  in  1  clear the whole register file.
- `wr_valid_i`  in  `NumReq`  per-requester write request.
- `wr_ready_o`  out  `NumReq`  write grant (one-hot or zero).
- `wr_addr_i`  in  `NumReq` x `NumRegsWidth`  write addresses.
- `wr_data_i`  in  `NumReq` x `DataWidth`  write data.
- `rd_valid_i`  in  `NumReq`  per-requester read request.
- `rd_ready_o`  out  `NumReq`  read grant (one-hot or zero).
- `rd_addr_i`  in  `NumReq` x `NumRegsWidth`  read addresses.
- `rd_rsp_valid_o`  out  1  read response valid.
- `rd_rsp_id_o`  out  `NumReqWidth`  index of the requester that owns the response.
- `rd_rsp_data_o`  out  `DataWidth`  read response data.
- `rf_clr_o`  out  1  to register file clear.
- `rf_wr_en_o`  out  1  to register file write enable.
- `rf_wr_addr_o`  out  `NumRegsWidth`  to register file write address.
- `rf_wr_data_o`  out  `DataWidth`  to register file write data.
- `rf_rd_addr_o`  out  `NumRegsWidth`  to register file read address.
- `rf_rd_data_i`  in  `DataWidth`  from register file read data (combinational).

## Operation
- Write arbiter:
  - Round-robin pointer `wr_ptr` (`NumReqWidth` bits).
  - Grant goes to the first asserted `wr_valid_i[k]`, searching from `wr_ptr` upward and wrapping at `NumReq-1`→0.
  - `wr_ready_o[k]=1` only for the granted index.
  - `rf_wr_en_o=1` when any grant exists; addr/data are muxed from the granted requester.
  - On grant, `wr_ptr` ← granted+1, modulo `NumReq`.
- Read arbiter:
  - Identical scheme with its own pointer `rd_ptr`.
  - `rf_rd_addr_o` is muxed from the granted requester; it is 0 when there is no grant.
- Read response:
  - On a read grant, at the next edge: `rd_rsp_valid_o`←1, `rd_rsp_id_o`←granted index, `rd_rsp_data_o`←`rf_rd_data_i`.
  - Otherwise `rd_rsp_valid_o`←0; ID and data hold.
  - There is no response backpressure; a requester must accept the response in the cycle it is valid.
- Clear:
  - `rf_clr_o = clr_i`, combinational.
  - While `clr_i=1`: all `wr_ready_o=0`, `rf_wr_en_o=0`, `wr_ptr` holds.
  - Reads are still granted and return pre-clear data.
- Same-cycle write and read to the same address: the response carries the old value (read-before-write).
- A requester must not make its valid depend on its own ready. Address and data must be held stable while valid is high and not yet granted.
- Non-granted requests are not lost; they wait. Round-robin bounds the wait to `NumReq-1` grants.

## Timing
- Grants, ready outputs and all `rf_*` outputs are combinational from valid/addr/`clr_i` and the pointer registers.
- Read latency: response is valid exactly 1 cycle after the grant cycle. Throughput is one read per cycle.
- Write takes effect at the grant edge. Throughput is one write per cycle; it is independent of reads.
- Reset values: `wr_ptr=0`, `rd_ptr=0`, `rd_rsp_valid_o=0`, `rd_rsp_id_o=0`, `rd_rsp_data_o=0`.
  - Combinational outputs are 0 when all valids are low.
- Reset mid-operation: any in-flight read response is dropped and `rd_rsp_valid_o` falls asynchronously. Pointers return to 0.

## Configuration
- `REG_ARB_FIXED_PRIO_EN`:
  - When defined, both arbiters use fixed priority: the lowest index wins, and `wr_ptr`/`rd_ptr` are removed (constant 0).
  - When undefined (default), round-robin as described above.
  - Handshake, latency and clear behaviour are identical in both builds.

## Test plan
- **Reset and idle:**
  - Assert `rst_ni=0` with all valids high. Release, then drop all valids.
  - Required: `rd_rsp_valid_o=0`, `rd_rsp_id_o=0`, `rd_rsp_data_o=0`, `rf_wr_en_o=0`.
- **Write then read:**
  - Requester 2 writes 0xDEADBEEF to addr 5, then requester 1 reads addr 5.
  - Required: `rf_wr_en_o=1` at the grant; one cycle after the read grant, `rd_rsp_valid_o=1`, `rd_rsp_id_o=1`, data 0xDEADBEEF.
- **Round-robin fairness:**
  - All 4 requesters hold `wr_valid_i` high for 8 cycles.
  - Required: grants 0,1,2,3,0,1,2,3. With `REG_ARB_FIXED_PRIO_EN` defined: requester 0 is granted all 8 cycles.
- **Read/write collision:**
  - addr 3 holds 0x11. In the same cycle, requester 0 writes 0x22 to addr 3 and requester 1 reads addr 3.
  - Required: response data 0x11; a following read returns 0x22.
- **Clear priority:**
  - `clr_i=1` while requesters 0 and 3 request writes.
  - Required: `rf_clr_o=1`, `wr_ready_o=0000`, `wr_ptr` unchanged. The next cycle with `clr_i=0` grants the same requester that would have been granted.
- **Reset mid-read:**
  - Assert `rst_ni` low in the cycle after a read grant.
  - Required: `rd_rsp_valid_o` goes 0 immediately, and no response appears after release.

Source files
------------

// File: rtl/reg_file_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_port_arbiter
// Purpose  : Shares the single write port and the single read port of a
//            1W/1R register file among NumReq requesters. Each port has its
//            own arbiter. A clear command is forwarded and blocks writes for
//            the cycles in which it is asserted. Read data is registered and
//            returned one cycle after the grant, tagged with the requester ID.
// Build    : REG_ARB_FIXED_PRIO_EN - when defined, both arbiters use fixed
//            priority (lowest index wins) and the round-robin pointers are
//            removed. Default (undefined) is round-robin.
// Ports    :
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clr_i                  clear request, forwarded as rf_clr_o
//   wr_valid_i/wr_ready_o  per-requester write handshake
//   wr_addr_i/wr_data_i    per-requester write address/data
//   rd_valid_i/rd_ready_o  per-requester read handshake
//   rd_addr_i              per-requester read address
//   rd_rsp_valid_o/id_o/data_o  registered read response
//   rf_clr_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, rf_rd_addr_o,
//   rf_rd_data_i           register-file side (read data is combinational)
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_port_arbiter #(
    parameter int NumReq       = 4,
    parameter int DataWidth    = 32,
    parameter int NumRegs      = 32,
    parameter int NumRegsWidth = $clog2(NumRegs),
    parameter int NumReqWidth  = $clog2(NumReq)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   clr_i,
    input  logic [NumReq-1:0]                      wr_valid_i,
    output logic [NumReq-1:0]                      wr_ready_o,
    input  logic [NumReq-1:0][NumRegsWidth-1:0]    wr_addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]       wr_data_i,
    input  logic [NumReq-1:0]                      rd_valid_i,
    output logic [NumReq-1:0]                      rd_ready_o,
    input  logic [NumReq-1:0][NumRegsWidth-1:0]    rd_addr_i,
    output logic                                   rd_rsp_valid_o,
    output logic [NumReqWidth-1:0]                 rd_rsp_id_o,
    output logic [DataWidth-1:0]                   rd_rsp_data_o,
    output logic                                   rf_clr_o,
    output logic                                   rf_wr_en_o,
    output logic [NumRegsWidth-1:0]                rf_wr_addr_o,
    output logic [DataWidth-1:0]                   rf_wr_data_o,
    output logic [NumRegsWidth-1:0]                rf_rd_addr_o,
    input  logic [DataWidth-1:0]                   rf_rd_data_i
);

    // Search requesters starting at ptr and wrapping at NumReq-1 -> 0.
    // Returns {found, index}.
    function automatic logic [NumReqWidth:0] rr_pick(
        input logic [NumReq-1:0]      req,
        input logic [NumReqWidth-1:0] ptr
    );
        logic                   found;
        logic [NumReqWidth-1:0] idx;
        logic [NumReqWidth-1:0] cand;
        int                     k;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NumReq; i++) begin
            k = int'(ptr) + i;
            if (k >= NumReq) begin
                k = k - NumReq;
            end
            cand = k[NumReqWidth-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    // Pointer value that follows a grant: granted + 1, modulo NumReq.
    function automatic logic [NumReqWidth-1:0] ptr_next(
        input logic [NumReqWidth-1:0] idx
    );
        if (idx == NumReqWidth'(NumReq - 1)) begin
            return '0;
        end
        return idx + NumReqWidth'(1);
    endfunction

    logic [NumReqWidth-1:0] w_wr_ptr;
    logic [NumReqWidth-1:0] w_rd_ptr;
    logic [NumReq-1:0]      w_wr_req;
    logic                   w_wr_gnt;
    logic [NumReqWidth-1:0] w_wr_idx;
    logic                   w_rd_gnt;
    logic [NumReqWidth-1:0] w_rd_idx;

    logic                   r_rsp_valid;
    logic [NumReqWidth-1:0] r_rsp_id;
    logic [DataWidth-1:0]   r_rsp_data;

    // Clear wins over writes: masking the requests removes the grant, the
    // write enable and the pointer update in one place.
    assign w_wr_req = clr_i ? '0 : wr_valid_i;

    assign {w_wr_gnt, w_wr_idx} = rr_pick(w_wr_req, w_wr_ptr);
    assign {w_rd_gnt, w_rd_idx} = rr_pick(rd_valid_i, w_rd_ptr);

`ifdef REG_ARB_FIXED_PRIO_EN
    // Fixed priority is round-robin with the search always starting at 0.
    assign w_wr_ptr = '0;
    assign w_rd_ptr = '0;
`else
    logic [NumReqWidth-1:0] r_wr_ptr;
    logic [NumReqWidth-1:0] r_rd_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_gnt) begin
                r_wr_ptr <= ptr_next(w_wr_idx);
            end
            if (w_rd_gnt) begin
                r_rd_ptr <= ptr_next(w_rd_idx);
            end
        end
    end

    assign w_wr_ptr = r_wr_ptr;
    assign w_rd_ptr = r_rd_ptr;
`endif

    // One-hot ready vectors.
    always_comb begin
        wr_ready_o = '0;
        rd_ready_o = '0;
        if (w_wr_gnt) begin
            wr_ready_o[w_wr_idx] = 1'b1;
        end
        if (w_rd_gnt) begin
            rd_ready_o[w_rd_idx] = 1'b1;
        end
    end

    // Register-file side; all address/data buses are zero without a grant.
    assign rf_clr_o     = clr_i;
    assign rf_wr_en_o   = w_wr_gnt;
    assign rf_wr_addr_o = w_wr_gnt ? wr_addr_i[w_wr_idx] : '0;
    assign rf_wr_data_o = w_wr_gnt ? wr_data_i[w_wr_idx] : '0;
    assign rf_rd_addr_o = w_rd_gnt ? rd_addr_i[w_rd_idx] : '0;

    // Read response. The register file is sampled at the grant edge, before
    // any same-cycle write lands, so a colliding read returns the old value.
    // ID and data hold when no read is granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_rd_gnt;
            if (w_rd_gnt) begin
                r_rsp_id   <= w_rd_idx;
                r_rsp_data <= rf_rd_data_i;
            end
        end
    end

    assign rd_rsp_valid_o = r_rsp_valid;
    assign rd_rsp_id_o    = r_rsp_id;
    assign rd_rsp_data_o  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_port_arbiter
// Purpose  : Self-checking bench for reg_file_port_arbiter. A behavioural
//            model (pointer integers, grant search, model memory) predicts
//            every combinational output and the registered read response
//            each cycle. Directed scenarios run first, then random traffic.
//            Honours REG_ARB_FIXED_PRIO_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_port_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int NG = 32;
    localparam int AW = 5;
    localparam int IW = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    clr;
    logic [NR-1:0]           wr_valid;
    logic [NR-1:0]           wr_ready;
    logic [NR-1:0][AW-1:0]   wr_addr;
    logic [NR-1:0][DW-1:0]   wr_data;
    logic [NR-1:0]           rd_valid;
    logic [NR-1:0]           rd_ready;
    logic [NR-1:0][AW-1:0]   rd_addr;
    logic                    rsp_valid;
    logic [IW-1:0]           rsp_id;
    logic [DW-1:0]           rsp_data;
    logic                    rf_clr;
    logic                    rf_wr_en;
    logic [AW-1:0]           rf_wr_addr;
    logic [DW-1:0]           rf_wr_data;
    logic [AW-1:0]           rf_rd_addr;
    logic [DW-1:0]           rf_rd_data;

    always #5 clk = ~clk;

    reg_file_port_arbiter #(
        .NumReq    (NR),
        .DataWidth (DW),
        .NumRegs   (NG)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clr_i          (clr),
        .wr_valid_i     (wr_valid),
        .wr_ready_o     (wr_ready),
        .wr_addr_i      (wr_addr),
        .wr_data_i      (wr_data),
        .rd_valid_i     (rd_valid),
        .rd_ready_o     (rd_ready),
        .rd_addr_i      (rd_addr),
        .rd_rsp_valid_o (rsp_valid),
        .rd_rsp_id_o    (rsp_id),
        .rd_rsp_data_o  (rsp_data),
        .rf_clr_o       (rf_clr),
        .rf_wr_en_o     (rf_wr_en),
        .rf_wr_addr_o   (rf_wr_addr),
        .rf_wr_data_o   (rf_wr_data),
        .rf_rd_addr_o   (rf_rd_addr),
        .rf_rd_data_i   (rf_rd_data)
    );

    // Register file environment: combinational read, write/clear at the edge.
    // It shares the reset so that grants shown during reset do not write.
    logic [DW-1:0] rf_mem [NG];
    assign rf_rd_data = rf_mem[rf_rd_addr];
    always @(posedge clk) begin
        if (rst_n) begin
            if (rf_clr) begin
                for (int i = 0; i < NG; i++) rf_mem[i] <= '0;
            end else if (rf_wr_en) begin
                rf_mem[rf_wr_addr] <= rf_wr_data;
            end
        end
    end

    // ---------------- reference model state ----------------
    int            m_wr_ptr;
    int            m_rd_ptr;
    logic [DW-1:0] m_mem [NG];
    bit            e_rsp_v;
    int            e_rsp_id;
    logic [DW-1:0] e_rsp_d;
    int            last_wg;
    int            last_rg;
    logic [NR-1:0] last_wr_ready;
    logic          last_wr_en;
    logic          last_clr;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // First requester with a request, searching upward from ptr with wrap.
    function automatic int pick(input logic [NR-1:0] req, input int ptr);
        for (int i = 0; i < NR; i++) begin
            int k;
            k = (ptr + i) % NR;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    function automatic int next_ptr(input int g);
`ifdef REG_ARB_FIXED_PRIO_EN
        return 0;
`else
        return (g + 1) % NR;
`endif
    endfunction

    // Called just after a negedge with inputs applied: checks this cycle's
    // outputs, advances the model across the coming edge, returns at the
    // next negedge.
    task automatic cycle();
        int            wg;
        int            rg;
        logic [NR-1:0] wreq;
        #1;
        wreq = clr ? '0 : wr_valid;
        wg   = pick(wreq, m_wr_ptr);
        rg   = pick(rd_valid, m_rd_ptr);
        chk("rf_clr",     rf_clr,     clr);
        chk("wr_ready",   wr_ready,   (wg >= 0) ? (64'd1 << wg) : 64'd0);
        chk("rf_wr_en",   rf_wr_en,   wg >= 0);
        chk("rf_wr_addr", rf_wr_addr, (wg >= 0) ? wr_addr[wg] : 0);
        chk("rf_wr_data", rf_wr_data, (wg >= 0) ? wr_data[wg] : 0);
        chk("rd_ready",   rd_ready,   (rg >= 0) ? (64'd1 << rg) : 64'd0);
        chk("rf_rd_addr", rf_rd_addr, (rg >= 0) ? rd_addr[rg] : 0);
        chk("rsp_valid",  rsp_valid,  e_rsp_v);
        chk("rsp_id",     rsp_id,     e_rsp_id);
        chk("rsp_data",   rsp_data,   e_rsp_d);
        last_wg       = wg;
        last_rg       = rg;
        last_wr_ready = wr_ready;
        last_wr_en    = rf_wr_en;
        last_clr      = rf_clr;
        // Read sees the memory before this cycle's write or clear.
        if (rg >= 0) begin
            e_rsp_v  = 1'b1;
            e_rsp_id = rg;
            e_rsp_d  = m_mem[rd_addr[rg]];
            m_rd_ptr = next_ptr(rg);
        end else begin
            e_rsp_v = 1'b0;
        end
        if (clr) begin
            for (int i = 0; i < NG; i++) m_mem[i] = '0;
        end else if (wg >= 0) begin
            m_mem[wr_addr[wg]] = wr_data[wg];
            m_wr_ptr = next_ptr(wg);
        end
        @(negedge clk);
    endtask

    // Asserts reset at the current time, checks the asynchronous effect,
    // holds two edges and releases at a negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id",    rsp_id,    0);
        chk("rst_rsp_data",  rsp_data,  0);
        m_wr_ptr = 0;
        m_rd_ptr = 0;
        e_rsp_v  = 1'b0;
        e_rsp_id = 0;
        e_rsp_d  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        clr      = 1'b0;
        wr_valid = '0;
        rd_valid = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b1;
        clr      = 1'b0;
        wr_valid = '1;
        rd_valid = '1;
        for (int i = 0; i < NR; i++) begin
            wr_addr[i] = AW'($urandom);
            wr_data[i] = $urandom;
            rd_addr[i] = AW'($urandom);
        end
        for (int i = 0; i < NG; i++) m_mem[i] = '0;
        m_wr_ptr = 0;
        m_rd_ptr = 0;
        e_rsp_v  = 1'b0;
        e_rsp_id = 0;
        e_rsp_d  = '0;
        #2;

        // Reset and idle: valids high during reset, dropped on release.
        do_reset();
        idle_inputs();
        cycle();
        chk("idle_wr_en", last_wr_en, 0);

        // Bring the environment memory to a known all-zero state.
        clr = 1'b1;
        cycle();
        clr = 1'b0;

        // Write then read.
        wr_valid   = 4'b0100;
        wr_addr[2] = 5'd5;
        wr_data[2] = 32'hDEADBEEF;
        cycle();
        chk("wt_wr_en", last_wr_en, 1);
        wr_valid   = '0;
        rd_valid   = 4'b0010;
        rd_addr[1] = 5'd5;
        cycle();
        rd_valid = '0;
        #1;
        chk("wt_rsp_valid", rsp_valid, 1);
        chk("wt_rsp_id",    rsp_id,    1);
        chk("wt_rsp_data",  rsp_data,  32'hDEADBEEF);
        cycle();

        // Fairness from reset: four writers held for eight cycles.
        do_reset();
        idle_inputs();
        wr_valid = '1;
        for (int i = 0; i < 8; i++) begin
            logic [NR-1:0] exp_rdy;
`ifdef REG_ARB_FIXED_PRIO_EN
            exp_rdy = 4'b0001;
`else
            exp_rdy = NR'(1 << (i % NR));
`endif
            cycle();
            chk("rr_grant", last_wr_ready, exp_rdy);
        end
        wr_valid = '0;

        // Read/write collision on addr 3.
        wr_valid   = 4'b0001;
        wr_addr[0] = 5'd3;
        wr_data[0] = 32'h11;
        cycle();
        wr_data[0] = 32'h22;
        rd_valid   = 4'b0010;
        rd_addr[1] = 5'd3;
        cycle();
        idle_inputs();
        #1;
        chk("col_old_data", rsp_data, 32'h11);
        rd_valid   = 4'b0010;
        cycle();
        rd_valid = '0;
        #1;
        chk("col_new_data", rsp_data, 32'h22);
        cycle();

        // Clear priority over writes from requesters 0 and 3.
        begin
            int exp_g;
            wr_valid = 4'b1001;
            exp_g    = pick(4'b1001, m_wr_ptr);
            clr      = 1'b1;
            cycle();
            chk("clr_out",       last_clr,      1);
            chk("clr_wr_ready",  last_wr_ready, 0);
            clr = 1'b0;
            cycle();
            chk("clr_next_grant", last_wr_ready, 64'd1 << exp_g);
            wr_valid = '0;
        end

        // Reset in the cycle after a read grant.
        rd_valid   = 4'b0100;
        rd_addr[2] = 5'd7;
        cycle();
        rd_valid = '0;
        #1;
        chk("mid_rsp_before", rsp_valid, 1);
        do_reset();
        idle_inputs();
        cycle();
        chk("mid_rsp_after", rsp_valid, 0);
        cycle();

        // Random traffic; a request not yet granted keeps its address/data.
        for (int n = 0; n < 400; n++) begin
            clr = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < NR; i++) begin
                if (!(wr_valid[i] && last_wg != i)) begin
                    wr_valid[i] = $urandom_range(0, 1);
                    wr_addr[i]  = AW'($urandom);
                    wr_data[i]  = $urandom;
                end
                if (!(rd_valid[i] && last_rg != i)) begin
                    rd_valid[i] = $urandom_range(0, 1);
                    rd_addr[i]  = AW'($urandom);
                end
            end
            cycle();
        end
        idle_inputs();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
